// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts a command byte out on device-generated clocks and checks the ack.
`timescale 1ns/1ps
module ps2_tx #(
  parameter int CLK_FREQ = 28_000_000
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic       rx_active,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int T_INH   = CLK_FREQ / 10000;
  localparam int T_RTS   = CLK_FREQ / 200000;
  localparam int T_START = CLK_FREQ * 15 / 1000;
  localparam int T_EDGE  = CLK_FREQ / 1000;
  localparam int CNT_W   = ($clog2(T_START + 1) > 19) ? $clog2(T_START + 1) : 19;

  // Each state lasts exactly T cycles: the counter runs T-1 down to 0.
  localparam logic [CNT_W-1:0] LD_INH   = CNT_W'(T_INH - 1);
  localparam logic [CNT_W-1:0] LD_RTS   = CNT_W'(T_RTS - 1);
  localparam logic [CNT_W-1:0] LD_START = CNT_W'(T_START - 1);
  localparam logic [CNT_W-1:0] LD_EDGE  = CNT_W'(T_EDGE - 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_INHIBIT    = 3'd1;
  localparam logic [2:0] S_RTS        = 3'd2;
  localparam logic [2:0] S_WAIT_START = 3'd3;
  localparam logic [2:0] S_SHIFT      = 3'd4;
  localparam logic [2:0] S_ACK        = 3'd5;
  localparam logic [2:0] S_WAIT_IDLE  = 3'd6;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  logic             clk_sync_p0, clk_sync_p1;
  logic             dat_sync_p0, dat_sync_p1;
  logic [7:0]       clk_hist, dat_hist;
  logic             clk_flt, dat_flt;
  logic             clk_flt_nxt, dat_flt_nxt;
  logic             fall_stb;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bitcnt;
  logic [7:0]       shift;
  logic             parity;

  // Filter decision: a level flips only once 8 identical samples are seen.
  always_comb begin
    clk_flt_nxt = clk_flt;
    if (&clk_hist)  clk_flt_nxt = 1'b1;
    if (~|clk_hist) clk_flt_nxt = 1'b0;
    dat_flt_nxt = dat_flt;
    if (&dat_hist)  dat_flt_nxt = 1'b1;
    if (~|dat_hist) dat_flt_nxt = 1'b0;
  end

  // Synchronize and filter both PS/2 lines; idle bus is high after reset.
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      clk_sync_p0 <= 1'b1;
      clk_sync_p1 <= 1'b1;
      dat_sync_p0 <= 1'b1;
      dat_sync_p1 <= 1'b1;
      clk_hist    <= 8'hFF;
      dat_hist    <= 8'hFF;
      clk_flt     <= 1'b1;
      dat_flt     <= 1'b1;
      fall_stb    <= 1'b0;
    end else begin
      // stage p0 -> p1: two-flop synchronizer
      clk_sync_p0 <= ps2_clk_in;
      clk_sync_p1 <= clk_sync_p0;
      dat_sync_p0 <= ps2_dat_in;
      dat_sync_p1 <= dat_sync_p0;
      // filter history and filtered level
      clk_hist    <= {clk_hist[6:0], clk_sync_p1};
      dat_hist    <= {dat_hist[6:0], dat_sync_p1};
      clk_flt     <= clk_flt_nxt;
      dat_flt     <= dat_flt_nxt;
      fall_stb    <= clk_flt & ~clk_flt_nxt;
    end
  end

  assign busy     = (state != S_IDLE);
  assign tx_ready = (state == S_IDLE) & ~rx_active;

  // Transmit sequencer: drives the open-drain enables and status pulses.
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bitcnt     <= '0;
      shift      <= '0;
      parity     <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        S_IDLE: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          if (tx_valid && tx_ready) begin
            shift      <= tx_data;
            parity     <= odd_parity(tx_data);
            bitcnt     <= '0;
            cnt        <= LD_INH;
            ps2_clk_oe <= 1'b1;
            state      <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (cnt == '0) begin
            cnt        <= LD_RTS;
            ps2_dat_oe <= 1'b1;
            state      <= S_RTS;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RTS: begin
          if (cnt == '0) begin
            cnt        <= LD_START;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b1;
            state      <= S_WAIT_START;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_WAIT_START: begin
          if (fall_stb) begin
            ps2_dat_oe <= ~shift[0];
            shift      <= {1'b0, shift[7:1]};
            bitcnt     <= 4'd1;
            cnt        <= LD_EDGE;
            state      <= S_SHIFT;
          end else if (cnt == '0) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_error   <= 1'b1;
            state      <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_SHIFT: begin
          if (fall_stb) begin
            cnt    <= LD_EDGE;
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt <= 4'd7) begin
              ps2_dat_oe <= ~shift[0];
              shift      <= {1'b0, shift[7:1]};
            end else if (bitcnt == 4'd8) begin
              ps2_dat_oe <= ~parity;
            end else begin
              // stop bit: release data and wait for the device ack
              ps2_dat_oe <= 1'b0;
              state      <= S_ACK;
            end
          end else if (cnt == '0) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_error   <= 1'b1;
            state      <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_ACK: begin
          if (fall_stb) begin
            if (!dat_flt) begin
              cnt   <= LD_EDGE;
              state <= S_WAIT_IDLE;
            end else begin
              ps2_clk_oe <= 1'b0;
              ps2_dat_oe <= 1'b0;
              tx_error   <= 1'b1;
              state      <= S_IDLE;
            end
          end else if (cnt == '0) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_error   <= 1'b1;
            state      <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_WAIT_IDLE: begin
          if (clk_flt && dat_flt) begin
            tx_done <= 1'b1;
            state   <= S_IDLE;
          end else if (cnt == '0) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_error   <= 1'b1;
            state      <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a behavioural PS/2 device on an open-drain bus sends
// clocks, collects the frame, and the result is compared with the byte sent.
`timescale 1ns/1ps
module tb_ps2_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int T_INH    = CLK_FREQ / 10000;
  localparam int T_RTS    = CLK_FREQ / 200000;
  localparam int T_START  = CLK_FREQ * 15 / 1000;
  localparam int T_EDGE   = CLK_FREQ / 1000;
  localparam int H        = CLK_FREQ / 12500 / 2;  // device half period

  logic       clk28 = 1'b0;
  logic       rst_n;
  logic       rx_active;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       ps2_clk_oe, ps2_dat_oe, tx_ready, busy, tx_done, tx_error;
  logic       dev_clk_low, dev_dat_low;
  wire        clk_line = ~(ps2_clk_oe | dev_clk_low);
  wire        dat_line = ~(ps2_dat_oe | dev_dat_low);

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  always #5 clk28 = ~clk28;

  ps2_tx #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk28      (clk28),
    .rst_n      (rst_n),
    .ps2_clk_in (clk_line),
    .ps2_dat_in (dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .rx_active  (rx_active),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  always @(negedge clk28) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done && tx_error) both_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk28);
  endtask

  // Present a byte once tx_ready is seen; scramble tx_data right after.
  task automatic start_tx(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 200) begin tick(1); n++; end
    check("ready_before_tx", tx_ready, 1'b1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  // Measure inhibit and request-to-send durations on the bus enables.
  task automatic host_request();
    int n = 0;
    check("inhibit_clk_oe", ps2_clk_oe, 1'b1);
    while (!ps2_dat_oe && n < T_INH + 50) begin tick(1); n++; end
    check("t_inh", n, T_INH);
    n = 0;
    while (ps2_clk_oe && n < T_RTS + 50) begin tick(1); n++; end
    check("t_rts", n, T_RTS);
    check("start_bit_oe", ps2_dat_oe, 1'b1);
  endtask

  // Device clocks npulses; samples data at the end of each low phase.
  task automatic dev_frame(input int npulses, input bit do_ack, output logic [10:0] bits);
    bits = '0;
    tick(H);
    for (int i = 0; i < npulses; i++) begin
      dev_clk_low = 1'b1;
      tick(H);
      bits[i] = dat_line;
      dev_clk_low = 1'b0;
      if (i == 9 && do_ack) dev_dat_low = 1'b1;
      tick(H);
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic send_and_check(input logic [7:0] d);
    logic [10:0] bits;
    int d0 = done_cnt;
    int e0 = err_cnt;
    int n = 0;
    logic exp_par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    start_tx(d);
    host_request();
    dev_frame(11, 1'b1, bits);
    while (done_cnt == d0 && err_cnt == e0 && n < 200) begin tick(1); n++; end
    tick(2);
    check("rx_byte", bits[7:0], d);
    check("rx_parity", bits[8], exp_par);
    check("rx_stop", bits[9], 1'b1);
    check("done_pulses", done_cnt - d0, 1);
    check("error_pulses", err_cnt - e0, 0);
    check("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    logic [10:0] bits;
    int n;
    int e0;
    int d0;
    rst_n = 1'b0; rx_active = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    dev_clk_low = 1'b0; dev_dat_low = 1'b0;
    tick(3);
    check("rst_clk_oe", ps2_clk_oe, 1'b0);
    check("rst_dat_oe", ps2_dat_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_error", tx_error, 1'b0);
    rst_n = 1'b1;
    tick(2);
    check("ready_after_rst", tx_ready, 1'b1);

    // directed bytes, then random ones
    send_and_check(8'hED);
    send_and_check(8'h02);
    for (int k = 0; k < 4; k++) send_and_check(8'($urandom));

    // device never clocks: start timeout
    e0 = err_cnt;
    start_tx(8'($urandom));
    host_request();
    n = 0;
    while (!tx_error && n < T_START + 100) begin tick(1); n++; end
    check("t_start_timeout", n, T_START);
    check("timeout_clk_oe", ps2_clk_oe, 1'b0);
    check("timeout_dat_oe", ps2_dat_oe, 1'b0);
    check("timeout_ready", tx_ready, 1'b1);
    tick(2);
    check("timeout_err_count", err_cnt - e0, 1);

    // device stops after 4 clocks: edge timeout measured from 4th clock fall
    e0 = err_cnt; d0 = done_cnt;
    start_tx(8'($urandom));
    host_request();
    dev_frame(3, 1'b0, bits);
    dev_clk_low = 1'b1;
    n = 0;
    while (!tx_error && n < T_EDGE + 200) begin
      tick(1); n++;
      if (n == H) dev_clk_low = 1'b0;
    end
    dev_clk_low = 1'b0;
    check("t_edge_window", (n >= T_EDGE + 10 && n <= T_EDGE + 14), 1'b1);
    tick(2);
    check("edge_err_count", err_cnt - e0, 1);
    check("edge_no_done", done_cnt - d0, 0);

    // device withholds the ack: error at the 11th clock fall
    e0 = err_cnt; d0 = done_cnt;
    start_tx(8'($urandom));
    host_request();
    dev_frame(10, 1'b0, bits);
    check("no_err_before_ack", err_cnt - e0, 0);
    dev_clk_low = 1'b1;
    n = 0;
    while (!tx_error && n < H) begin tick(1); n++; end
    check("nack_err_latency", (n >= 10 && n <= 14), 1'b1);
    tick(H - n);
    dev_clk_low = 1'b0;
    tick(H);
    check("nack_err_count", err_cnt - e0, 1);
    check("nack_no_done", done_cnt - d0, 0);

    // receiver busy: request is blocked and not queued
    rx_active = 1'b1;
    tick(1);
    tx_valid = 1'b1; tx_data = 8'($urandom);
    tick(20);
    check("rx_active_ready", tx_ready, 1'b0);
    check("rx_active_clk_oe", ps2_clk_oe, 1'b0);
    check("rx_active_dat_oe", ps2_dat_oe, 1'b0);
    tx_valid = 1'b0;
    tick(1);
    rx_active = 1'b0;
    tick(5);
    check("not_queued_busy", busy, 1'b0);
    check("not_queued_clk_oe", ps2_clk_oe, 1'b0);

    // reset asserted during SHIFT
    e0 = err_cnt; d0 = done_cnt;
    start_tx(8'($urandom));
    host_request();
    dev_frame(3, 1'b0, bits);
    check("shift_busy", busy, 1'b1);
    rst_n = 1'b0;
    tick(1);
    check("midrst_clk_oe", ps2_clk_oe, 1'b0);
    check("midrst_dat_oe", ps2_dat_oe, 1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(20);
    check("midrst_no_error", err_cnt - e0, 0);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_ready", tx_ready, 1'b1);

    check("done_error_overlap", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
